// File: rtl/cpu_ctrl.sv
// cpu_ctrl: host-side controller for a small CPU core.
//   Accepts host commands (valid/ready) to load the program ROM two bytes per
//   instruction word, run, halt, single-step and manage one breakpoint.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   cmd_valid/ready   command handshake (ready is low only while reset is high)
//   cmd_op, cmd_arg   opcode and 8-bit argument
//   pc                CPU program counter, compared against the breakpoint
//   cpu_en, cpu_rst   CPU execute enable (combinational) and CPU reset
//   rom_we/waddr/wdata program-ROM write port, wdata = {addr_w, addr_r}
//   state             0 HALTED, 1 LOAD, 2 RUN, 3 STEP
//   err               sticky illegal-command flag
module cpu_ctrl #(
  parameter int ROM_SIZE = 8,
  parameter int RAM_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [7:0]            cmd_arg,
  input  logic [ROM_SIZE-1:0]   pc,
  output logic                  cpu_en,
  output logic                  cpu_rst,
  output logic                  rom_we,
  output logic [ROM_SIZE-1:0]   rom_waddr,
  output logic [2*RAM_SIZE-1:0] rom_wdata,
  output logic [1:0]            state,
  output logic                  err
);

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_STEP   = 2'd3
  } state_t;

  localparam logic [2:0] OP_LOAD_BEGIN = 3'd1;
  localparam logic [2:0] OP_LOAD_BYTE  = 3'd2;
  localparam logic [2:0] OP_RUN        = 3'd3;
  localparam logic [2:0] OP_HALT       = 3'd4;
  localparam logic [2:0] OP_STEP       = 3'd5;
  localparam logic [2:0] OP_SET_BP     = 3'd6;
  localparam logic [2:0] OP_CLR_BP     = 3'd7;

  state_t                cur_state;
  state_t                nxt_state;
  logic                  phase;
  logic [8:0]            step_cnt;
  logic [ROM_SIZE-1:0]   bp_addr;
  logic                  bp_valid;
  logic                  resume;
  logic                  accept;
  logic                  bp_hit;

  function automatic logic [RAM_SIZE-1:0] arg_half(input logic [7:0] a);
    logic [31:0] t;
    t = {24'd0, a};
    return t[RAM_SIZE-1:0];
  endfunction

  function automatic logic [ROM_SIZE-1:0] arg_addr(input logic [7:0] a);
    logic [31:0] t;
    t = {24'd0, a};
    return t[ROM_SIZE-1:0];
  endfunction

  assign state = cur_state;

  always_comb begin
    cmd_ready = !reset;
    accept    = cmd_valid && cmd_ready;
    // resume masks the breakpoint for the first instruction after RUN, so a
    // CPU parked on bp_addr can step past it.
    bp_hit    = bp_valid && (pc == bp_addr) && !resume;

    cpu_en    = 1'b0;
    nxt_state = cur_state;
    case (cur_state)
      ST_RUN: begin
        cpu_en = !bp_hit;
        if (bp_hit) nxt_state = ST_HALTED;
      end
      ST_STEP: begin
        cpu_en = (step_cnt != 9'd0);
        if (step_cnt <= 9'd1) nxt_state = ST_HALTED;
      end
      default: ;
    endcase

    // Host commands override the automatic transitions above.
    if (accept) begin
      case (cmd_op)
        OP_LOAD_BEGIN: nxt_state = ST_LOAD;
        OP_RUN:        if (cur_state == ST_HALTED || cur_state == ST_LOAD) nxt_state = ST_RUN;
        OP_HALT:       nxt_state = ST_HALTED;
        OP_STEP:       if (cur_state == ST_HALTED) nxt_state = ST_STEP;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cur_state <= ST_HALTED;
    else       cur_state <= nxt_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rst   <= 1'b1;
      rom_we    <= 1'b0;
      rom_waddr <= '0;
      rom_wdata <= '0;
      bp_addr   <= '0;
      bp_valid  <= 1'b0;
      phase     <= 1'b0;
      step_cnt  <= 9'd0;
      resume    <= 1'b0;
      err       <= 1'b0;
    end else begin
      // The write strobe lasts one cycle; the address advances right after it.
      rom_we <= 1'b0;
      if (rom_we) rom_waddr <= rom_waddr + 1'b1;
      if (cpu_en && cur_state == ST_RUN)  resume   <= 1'b0;
      if (cpu_en && cur_state == ST_STEP) step_cnt <= step_cnt - 9'd1;

      if (accept) begin
        case (cmd_op)
          OP_LOAD_BEGIN: begin
            rom_waddr <= arg_addr(cmd_arg);
            phase     <= 1'b0;
            cpu_rst   <= 1'b1;
          end
          OP_LOAD_BYTE: begin
            if (cur_state == ST_LOAD) begin
              if (!phase) begin
                rom_wdata[RAM_SIZE-1:0] <= arg_half(cmd_arg);
                phase                   <= 1'b1;
              end else begin
                rom_wdata[2*RAM_SIZE-1:RAM_SIZE] <= arg_half(cmd_arg);
                rom_we                           <= 1'b1;
                phase                            <= 1'b0;
              end
            end else begin
              err <= 1'b1;
            end
          end
          OP_RUN: begin
            if (cur_state == ST_HALTED || cur_state == ST_LOAD) begin
              cpu_rst <= 1'b0;
              resume  <= 1'b1;
              phase   <= 1'b0;
            end
          end
          OP_HALT: phase <= 1'b0;
          OP_STEP: begin
            if (cur_state == ST_HALTED) begin
              step_cnt <= (cmd_arg == 8'd0) ? 9'd256 : {1'b0, cmd_arg};
              cpu_rst  <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
          OP_SET_BP: begin
            bp_addr  <= arg_addr(cmd_arg);
            bp_valid <= 1'b1;
          end
          OP_CLR_BP: bp_valid <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed testbench for cpu_ctrl. A tiny CPU model advances pc whenever
// cpu_en is high and clears it while cpu_rst is high.
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [7:0]  cmd_arg = 8'd0;
  logic [7:0]  pc = 8'd0;
  logic        cpu_en;
  logic        cpu_rst;
  logic        rom_we;
  logic [7:0]  rom_waddr;
  logic [15:0] rom_wdata;
  logic [1:0]  state;
  logic        err;

  int total = 0;
  int bad   = 0;
  int nwe   = 0;
  logic [7:0]  wa [16];
  logic [15:0] wd [16];

  cpu_ctrl #(.ROM_SIZE(8), .RAM_SIZE(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .pc(pc), .cpu_en(cpu_en),
    .cpu_rst(cpu_rst), .rom_we(rom_we), .rom_waddr(rom_waddr),
    .rom_wdata(rom_wdata), .state(state), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cpu_rst === 1'b1)     pc <= 8'd0;
    else if (cpu_en === 1'b1) pc <= pc + 8'd1;
  end

  always @(negedge clk) begin
    if (rom_we === 1'b1) begin
      if (nwe < 16) begin
        wa[nwe] = rom_waddr;
        wd[nwe] = rom_wdata;
      end
      nwe++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] arg);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_arg   = 8'd0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b1; cmd_op = 3'd1; cmd_arg = 8'h55;
    tick(); tick();
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %0b want 0", cmd_ready); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", state); end
    total++; if (cpu_rst !== 1'b1) begin bad++; $display("FAIL rst_cpu_rst: got %0b want 1", cpu_rst); end
    total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL rst_cpu_en: got %0b want 0", cpu_en); end
    total++; if (rom_we !== 1'b0) begin bad++; $display("FAIL rst_rom_we: got %0b want 0", rom_we); end
    total++; if (rom_waddr !== 8'h00) begin bad++; $display("FAIL rst_waddr: got %0h want 0", rom_waddr); end
    total++; if (rom_wdata !== 16'h0000) begin bad++; $display("FAIL rst_wdata: got %0h want 0", rom_wdata); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %0b want 0", err); end
    @(negedge clk);
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 8'd0;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL ready_after_rst: got %0b want 1", cmd_ready); end
  endtask

  task automatic test_load();
    int base;
    base = nwe;
    send(3'd1, 8'h10);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL load_state: got %0d want 1", state); end
    total++; if (cpu_rst !== 1'b1 || cpu_en !== 1'b0) begin bad++; $display("FAIL load_cpu: got rst=%0b en=%0b want rst=1 en=0", cpu_rst, cpu_en); end
    total++; if (rom_waddr !== 8'h10) begin bad++; $display("FAIL load_waddr: got %0h want 10", rom_waddr); end
    send(3'd2, 8'h05);
    total++; if (rom_we !== 1'b0) begin bad++; $display("FAIL load_half_we: got %0b want 0", rom_we); end
    send(3'd2, 8'h01);
    total++; if (rom_we !== 1'b1) begin bad++; $display("FAIL load_we: got %0b want 1", rom_we); end
    total++; if (rom_waddr !== 8'h10) begin bad++; $display("FAIL load_we_addr: got %0h want 10", rom_waddr); end
    total++; if (rom_wdata !== 16'h0105) begin bad++; $display("FAIL load_we_data: got %0h want 0105", rom_wdata); end
    tick();
    total++; if (rom_we !== 1'b0) begin bad++; $display("FAIL load_we_pulse: got %0b want 0", rom_we); end
    total++; if (rom_waddr !== 8'h11) begin bad++; $display("FAIL load_addr_inc: got %0h want 11", rom_waddr); end
    total++; if (nwe - base !== 1) begin bad++; $display("FAIL load_we_count: got %0d want 1", nwe - base); end
  endtask

  task automatic test_wrap();
    int base;
    base = nwe;
    send(3'd1, 8'hFF);
    send(3'd2, 8'hA1);
    send(3'd2, 8'hB1);
    total++; if (rom_waddr !== 8'hFF || rom_we !== 1'b1) begin bad++; $display("FAIL wrap_first: got addr=%0h we=%0b want addr=ff we=1", rom_waddr, rom_we); end
    send(3'd2, 8'hA2);
    send(3'd2, 8'hB2);
    total++; if (rom_waddr !== 8'h00 || rom_wdata !== 16'hB2A2) begin bad++; $display("FAIL wrap_second: got addr=%0h data=%0h want addr=0 data=b2a2", rom_waddr, rom_wdata); end
    tick();
    total++; if (rom_waddr !== 8'h01) begin bad++; $display("FAIL wrap_next_addr: got %0h want 01", rom_waddr); end
    total++; if (nwe - base !== 2) begin bad++; $display("FAIL wrap_count: got %0d want 2", nwe - base); end
    total++; if (wa[base] !== 8'hFF || wd[base] !== 16'hB1A1) begin bad++; $display("FAIL wrap_rec0: got %0h/%0h want ff/b1a1", wa[base], wd[base]); end
    total++; if (wa[base+1] !== 8'h00) begin bad++; $display("FAIL wrap_rec1: got %0h want 00", wa[base+1]); end
  endtask

  task automatic test_halt_discard();
    int base;
    base = nwe;
    send(3'd1, 8'h20);
    send(3'd2, 8'h33);
    send(3'd0, 8'h99);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL nop_state: got %0d want 1", state); end
    send(3'd4, 8'h00);
    total++; if (state !== 2'd0 || cpu_en !== 1'b0) begin bad++; $display("FAIL halt_state: got st=%0d en=%0b want st=0 en=0", state, cpu_en); end
    tick(); tick();
    total++; if (nwe !== base) begin bad++; $display("FAIL halt_no_we: got %0d writes want 0", nwe - base); end
    send(3'd1, 8'h20);
    send(3'd2, 8'h44);
    send(3'd2, 8'h55);
    total++; if (rom_we !== 1'b1 || rom_waddr !== 8'h20 || rom_wdata !== 16'h5544) begin bad++; $display("FAIL halt_reload: got we=%0b addr=%0h data=%0h want 1/20/5544", rom_we, rom_waddr, rom_wdata); end
  endtask

  task automatic run_step(input logic [7:0] arg, input int want, input int bound);
    int n;
    send(3'd4, 8'h00);
    send(3'd5, arg);
    total++; if (state !== 2'd3) begin bad++; $display("FAIL step_enter: got %0d want 3", state); end
    n = 0;
    for (int i = 0; i < bound; i++) begin
      if (cpu_en === 1'b1) n++;
      tick();
    end
    total++; if (n !== want) begin bad++; $display("FAIL step_cycles_%0d: got %0d want %0d", arg, n, want); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL step_done_state: got %0d want 0", state); end
  endtask

  task automatic test_step();
    run_step(8'd3, 3, 20);
    run_step(8'd1, 1, 10);
    run_step(8'd0, 256, 300);
  endtask

  task automatic test_breakpoint();
    int k;
    send(3'd1, 8'h00);
    send(3'd6, 8'h04);
    send(3'd3, 8'h00);
    total++; if (state !== 2'd2 || cpu_rst !== 1'b0) begin bad++; $display("FAIL bp_run: got st=%0d rst=%0b want 2/0", state, cpu_rst); end
    total++; if (pc !== 8'h00 || cpu_en !== 1'b1) begin bad++; $display("FAIL bp_start: got pc=%0h en=%0b want 0/1", pc, cpu_en); end
    k = 0;
    while (pc !== 8'h04 && k < 20) begin
      total++; if (cpu_en !== 1'b1) begin bad++; $display("FAIL bp_run_en: got %0b want 1 at pc=%0h", cpu_en, pc); end
      tick();
      k++;
    end
    total++; if (pc !== 8'h04) begin bad++; $display("FAIL bp_reach: got pc=%0h want 04", pc); end
    total++; if (cpu_en !== 1'b0 || state !== 2'd2) begin bad++; $display("FAIL bp_hit: got en=%0b st=%0d want 0/2", cpu_en, state); end
    tick();
    total++; if (state !== 2'd0 || cpu_en !== 1'b0 || pc !== 8'h04) begin bad++; $display("FAIL bp_halted: got st=%0d en=%0b pc=%0h want 0/0/04", state, cpu_en, pc); end
    tick();
    total++; if (pc !== 8'h04) begin bad++; $display("FAIL bp_hold_pc: got %0h want 04", pc); end
    send(3'd3, 8'h00);
    total++; if (state !== 2'd2 || pc !== 8'h04 || cpu_en !== 1'b1) begin bad++; $display("FAIL bp_resume: got st=%0d pc=%0h en=%0b want 2/04/1", state, pc, cpu_en); end
    tick();
    total++; if (pc !== 8'h05 || cpu_en !== 1'b1 || state !== 2'd2) begin bad++; $display("FAIL bp_continue: got pc=%0h en=%0b st=%0d want 05/1/2", pc, cpu_en, state); end
    send(3'd7, 8'h00);
    send(3'd4, 8'h00);
    send(3'd1, 8'h00);
    send(3'd3, 8'h00);
    total++; if (pc !== 8'h00) begin bad++; $display("FAIL clrbp_start: got pc=%0h want 0", pc); end
    repeat (8) tick();
    total++; if (pc !== 8'h08 || state !== 2'd2) begin bad++; $display("FAIL clrbp_pass: got pc=%0h st=%0d want 08/2", pc, state); end
    send(3'd3, 8'h00);
    total++; if (state !== 2'd2 || cpu_en !== 1'b1) begin bad++; $display("FAIL run_in_run: got st=%0d en=%0b want 2/1", state, cpu_en); end
  endtask

  task automatic test_err();
    int base;
    base = nwe;
    send(3'd2, 8'h77);
    total++; if (err !== 1'b1 || state !== 2'd2) begin bad++; $display("FAIL err_set: got err=%0b st=%0d want 1/2", err, state); end
    tick(); tick();
    total++; if (nwe !== base) begin bad++; $display("FAIL err_no_we: got %0d writes want 0", nwe - base); end
    send(3'd4, 8'h00);
    send(3'd1, 8'h00);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %0b want 1", err); end
  endtask

  task automatic test_reset_midload();
    int base;
    send(3'd1, 8'h30);
    send(3'd2, 8'h12);
    base = nwe;
    @(negedge clk);
    reset = 1'b1; cmd_valid = 1'b1; cmd_op = 3'd2; cmd_arg = 8'h34;
    tick(); tick();
    total++; if (state !== 2'd0 || cpu_rst !== 1'b1 || cpu_en !== 1'b0 || rom_we !== 1'b0) begin bad++; $display("FAIL midrst_ctrl: got st=%0d rst=%0b en=%0b we=%0b want 0/1/0/0", state, cpu_rst, cpu_en, rom_we); end
    total++; if (rom_waddr !== 8'h00 || rom_wdata !== 16'h0000 || err !== 1'b0) begin bad++; $display("FAIL midrst_data: got addr=%0h data=%0h err=%0b want 0/0/0", rom_waddr, rom_wdata, err); end
    @(negedge clk);
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 8'd0;
    tick(); tick();
    total++; if (nwe !== base || state !== 2'd0) begin bad++; $display("FAIL midrst_after: got writes=%0d st=%0d want 0/0", nwe - base, state); end
    send(3'd1, 8'h40);
    send(3'd2, 8'h01);
    send(3'd2, 8'h02);
    total++; if (rom_we !== 1'b1 || rom_waddr !== 8'h40 || rom_wdata !== 16'h0201) begin bad++; $display("FAIL midrst_reload: got we=%0b addr=%0h data=%0h want 1/40/0201", rom_we, rom_waddr, rom_wdata); end
  endtask

  task automatic test_step_err();
    send(3'd5, 8'h02);
    total++; if (err !== 1'b1 || state !== 2'd1 || cpu_en !== 1'b0) begin bad++; $display("FAIL step_in_load: got err=%0b st=%0d en=%0b want 1/1/0", err, state, cpu_en); end
    send(3'd3, 8'h00);
    total++; if (state !== 2'd2) begin bad++; $display("FAIL run_from_load: got %0d want 2", state); end
    send(3'd5, 8'h02);
    total++; if (state !== 2'd2) begin bad++; $display("FAIL step_in_run: got %0d want 2", state); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_wrap();
    test_halt_discard();
    test_step();
    test_breakpoint();
    test_err();
    test_reset_midload();
    test_step_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 SHALL have parameter ROM_SIZE, default 8, meaning CPU program-ROM address width.
REQ-002 SHALL have parameter RAM_SIZE, default 8, meaning CPU RAM address width; an instruction word is 2*RAM_SIZE bits, {addr_w, addr_r}.
REQ-003 SHALL have port clk, input, 1 bit, meaning clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit, meaning synchronous active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1 bit, meaning a host command is present.
REQ-006 SHALL have port cmd_ready, output, 1 bit, meaning a command is accepted when cmd_valid & cmd_ready.
REQ-007 SHALL have port cmd_op, input, 3 bits, meaning opcode: 0 NOP, 1 LOAD_BEGIN, 2 LOAD_BYTE, 3 RUN, 4 HALT, 5 STEP, 6 SET_BP, 7 CLR_BP.
REQ-008 SHALL have port cmd_arg, input, 8 bits, meaning command argument.
REQ-009 SHALL have port pc, input, ROM_SIZE bits, meaning the CPU's current program counter.
REQ-010 SHALL have port cpu_en, output, 1 bit, meaning the CPU executes one instruction in the cycle it is high.
REQ-011 SHALL have port cpu_rst, output, 1 bit, meaning synchronous reset to the CPU.
REQ-012 SHALL have port rom_we, output, 1 bit, meaning program-ROM write strobe.
REQ-013 SHALL have port rom_waddr, output, ROM_SIZE bits, meaning the ROM write address.
REQ-014 SHALL have port rom_wdata, output, 2*RAM_SIZE bits, meaning the ROM write data.
REQ-015 SHALL have port state, output, 2 bits, meaning 0 HALTED, 1 LOAD, 2 RUN, 3 STEP.
REQ-016 SHALL have port err, output, 1 bit, meaning sticky illegal-command flag.

Function
REQ-017 cmd_ready SHALL be 1 in every cycle except while reset is high.
REQ-018 NOP SHALL have no effect in any state.
REQ-019 LOAD_BEGIN SHALL be accepted in any state: rom_waddr <= cmd_arg[ROM_SIZE-1:0], byte phase <= low, state -> LOAD.
REQ-020 In LOAD, cpu_rst SHALL be 1 and cpu_en SHALL be 0.
REQ-021 LOAD_BYTE in LOAD SHALL work as follows: on low phase, latch cmd_arg as addr_r (rom_wdata low half), phase -> high; on high phase, latch as addr_w (high half), assert rom_we for exactly the next cycle, phase -> low.
REQ-022 During the rom_we cycle, rom_waddr and rom_wdata SHALL be stable; rom_waddr SHALL increment by 1 in the cycle after the rom_we cycle, wrapping 2^ROM_SIZE-1 -> 0.
REQ-023 LOAD_BYTE outside LOAD SHALL be dropped and SHALL set err.
REQ-024 RUN from HALTED or LOAD SHALL set state -> RUN; cpu_rst SHALL be 0 from the next cycle; RUN while already in RUN or STEP SHALL have no effect.
REQ-025 HALT in any state SHALL set state -> HALTED, with cpu_en 0 from the next cycle; a half-loaded word (phase high) SHALL be discarded without rom_we.
REQ-026 STEP from HALTED SHALL load a step counter with cmd_arg (0 means 256) and set state -> STEP; STEP in any other state SHALL be dropped and SHALL set err.
REQ-027 In STEP, cpu_en SHALL be 1 for exactly the loaded number of cycles; the counter decrements each such cycle, and the state returns to HALTED when it reaches 0; breakpoints SHALL be ignored.
REQ-028 SET_BP SHALL store cmd_arg[ROM_SIZE-1:0] as bp_addr with bp_valid=1; CLR_BP SHALL clear bp_valid; both SHALL be legal in any state.
REQ-029 In RUN, cpu_en SHALL be combinationally 0 whenever bp_valid & pc==bp_addr & !resume, and the state SHALL go to HALTED in that cycle, so the instruction at bp_addr is not executed.
REQ-030 The resume flag SHALL be set on entry to RUN and cleared after the first cpu_en cycle, so RUN issued while halted at bp_addr executes that instruction.
REQ-031 In RUN, cpu_en SHALL be 1 in every other cycle.
REQ-032 In HALTED, cpu_en SHALL be 0 and cpu_rst SHALL hold its previous value.

Reset
REQ-033 While reset is high, the block SHALL drive state=HALTED, cpu_rst=1, cpu_en=0, rom_we=0, rom_waddr=0, rom_wdata=0, bp_valid=0, phase=low, step counter=0, resume=0, err=0.
REQ-034 Reset SHALL take priority over any command, including in the middle of a load or a step.

Verification
REQ-035 Scenario: LOAD_BEGIN 0x10, LOAD_BYTE 0x05, LOAD_BYTE 0x01 -> a single rom_we with rom_waddr=0x10 and rom_wdata=0x0105, then rom_waddr=0x11.
REQ-036 Scenario: LOAD_BEGIN 0xFF, then 4 LOAD_BYTEs -> writes at 0xFF then 0x00 (wrap-around).
REQ-037 Scenario: HALTED, STEP 3 -> cpu_en high for exactly 3 cycles, then state=HALTED; STEP 0 -> 256 cycles.
REQ-038 Scenario: SET_BP 0x04, RUN with pc counting 0,1,2... -> cpu_en=0 in the cycle pc=0x04, state=HALTED; RUN again -> cpu_en=1 at pc=0x04 and execution continues.
REQ-039 Scenario: LOAD_BYTE while in RUN -> err=1, no rom_we; err is cleared only by reset.
REQ-040 Scenario: reset asserted mid-load after one LOAD_BYTE -> no rom_we, all outputs take their REQ-033 values.
